// File: rtl/cordic_peak_detector_pkg.sv
// Shared types and field layout for the CORDIC peak detector.
package cordic_pkg;

  typedef enum logic [1:0] {ACCUM, SEND0, SEND1} state_e;

  localparam int unsigned MAG_MSB   = 31;
  localparam int unsigned MAG_LSB   = 16;
  localparam int unsigned PHASE_MSB = 15;
  localparam int unsigned PHASE_LSB = 0;
  localparam int unsigned MAG_W     = MAG_MSB - MAG_LSB + 1;
  localparam int unsigned PHASE_W   = PHASE_MSB - PHASE_LSB + 1;

  localparam int unsigned SUM_HALF_W    = 16;
  localparam int unsigned CNT_WIDTH_DEF = 16;

  // Beat0: {peak mag, peak phase}; beat1: {frame length, peak index}.
  typedef struct packed {
    logic [SUM_HALF_W-1:0] hi;
    logic [SUM_HALF_W-1:0] lo;
  } summary_t;

endpackage

// File: rtl/cordic_peak_detector_tracker.sv
// Per-frame peak magnitude/phase/index tracking with a saturating beat counter.
module cordic_peak_tracker
  import cordic_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample,
  input  logic                 clear,
  input  logic [MAG_W-1:0]     mag,
  input  logic [PHASE_W-1:0]   phase,
  output logic [MAG_W-1:0]     peak,
  output logic [PHASE_W-1:0]   peak_phase,
  output logic [CNT_WIDTH-1:0] peak_idx,
  output logic [CNT_WIDTH-1:0] count,
  output logic [MAG_W-1:0]     peak_nxt_c,
  output logic [PHASE_W-1:0]   phase_nxt_c
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic load_c;

  // Strict compare keeps the first of equal magnitudes.
  assign load_c      = sample && ((count == CNT_WIDTH'(0)) || (mag > peak));
  assign peak_nxt_c  = load_c ? mag : peak;
  assign phase_nxt_c = load_c ? phase : peak_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak       <= '0;
      peak_phase <= '0;
      peak_idx   <= '0;
      count      <= '0;
    end else if (clear) begin
      peak       <= '0;
      peak_phase <= '0;
      peak_idx   <= '0;
      count      <= '0;
    end else if (sample) begin
      if (load_c) begin
        peak       <= mag;
        peak_phase <= phase;
        peak_idx   <= count;
      end
      if (count != CNT_MAX) count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cordic_peak_detector.sv
// Consumes CORDIC {mag, phase} frames and emits a two-beat peak summary per frame.
module cordic_peak_detector
  import cordic_pkg::*;
#(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH              = CNT_WIDTH_DEF
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast
);

  state_e                 state, state_nxt;
  summary_t               tdata_q, tdata_nxt;
  logic                   tvalid_nxt, tlast_nxt, tready_nxt;
  logic                   beat_c, clear_c;
  logic [MAG_W-1:0]       peak, peak_nxt_c;
  logic [PHASE_W-1:0]     peak_phase, phase_nxt_c;
  logic [CNT_WIDTH-1:0]   peak_idx, count;
  logic                   unused_strb;

  assign unused_strb = ^s00_axis_tstrb;
  assign beat_c      = s00_axis_tvalid && s00_axis_tready;

  cordic_peak_tracker #(.CNT_WIDTH(CNT_WIDTH)) u_tracker (
    .clk         (s00_axis_aclk),
    .rst_n       (s00_axis_aresetn),
    .sample      (beat_c),
    .clear       (clear_c),
    .mag         (s00_axis_tdata[MAG_MSB:MAG_LSB]),
    .phase       (s00_axis_tdata[PHASE_MSB:PHASE_LSB]),
    .peak        (peak),
    .peak_phase  (peak_phase),
    .peak_idx    (peak_idx),
    .count       (count),
    .peak_nxt_c  (peak_nxt_c),
    .phase_nxt_c (phase_nxt_c)
  );

  // Beat0 is built from the tracker's next values so the tlast beat is included.
  always_comb begin
    state_nxt  = state;
    tvalid_nxt = m00_axis_tvalid;
    tlast_nxt  = m00_axis_tlast;
    tdata_nxt  = tdata_q;
    clear_c    = 1'b0;
    case (state)
      ACCUM: begin
        if (beat_c && s00_axis_tlast) begin
          state_nxt  = SEND0;
          tvalid_nxt = 1'b1;
          tlast_nxt  = 1'b0;
          tdata_nxt  = '{hi: SUM_HALF_W'(peak_nxt_c), lo: SUM_HALF_W'(phase_nxt_c)};
        end
      end
      SEND0: begin
        if (m00_axis_tready) begin
          state_nxt = SEND1;
          tlast_nxt = 1'b1;
          tdata_nxt = '{hi: SUM_HALF_W'(count), lo: SUM_HALF_W'(peak_idx)};
        end
      end
      SEND1: begin
        if (m00_axis_tready) begin
          state_nxt  = ACCUM;
          tvalid_nxt = 1'b0;
          tlast_nxt  = 1'b0;
          clear_c    = 1'b1;
        end
      end
      default: state_nxt = ACCUM;
    endcase
    tready_nxt = (state_nxt == ACCUM);
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state           <= ACCUM;
      s00_axis_tready <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      tdata_q         <= '0;
    end else begin
      state           <= state_nxt;
      s00_axis_tready <= tready_nxt;
      m00_axis_tvalid <= tvalid_nxt;
      m00_axis_tlast  <= tlast_nxt;
      tdata_q         <= tdata_nxt;
    end
  end

  assign m00_axis_tdata = tdata_q;
  assign m00_axis_tstrb = '1;

endmodule

// File: tb/tb_cordic_peak_detector.sv
// Directed-vector bench for cordic_peak_detector with hand-computed summaries.
module tb_cordic_peak_detector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = 4'h0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic        m_tready = 1'b0;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;

  int n_vec = 0;
  int n_err = 0;

  cordic_peak_detector dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tready  (s_tready),
    .m00_axis_tready  (m_tready),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tstrb   (m_tstrb),
    .m00_axis_tlast   (m_tlast)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [15:0] mag, input logic [15:0] ph, input logic last);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = {mag, ph};
    s_tlast  = last;
    while (!s_tready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check_eq("rdy_timeout", 32'(s_tready), 32'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic get_summary(output logic [31:0] b0, output logic [31:0] b1,
                             input int st0, input int st1, output int lows);
    int n = 0;
    lows = 0;
    while (!m_tvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("b0_valid", 32'(m_tvalid), 32'd1);
    check_eq("b0_last", 32'(m_tlast), 32'd0);
    check_eq("strb", 32'(m_tstrb), 32'hF);
    b0 = m_tdata;
    if (!s_tready) lows++;
    for (int i = 0; i < st0; i++) begin
      @(posedge clk); #1;
      check_eq("b0_hold", m_tdata, b0);
      check_eq("b0_hold_vl", {30'd0, m_tvalid, m_tlast}, 32'd2);
      if (!s_tready) lows++;
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
    check_eq("b1_valid_last", {30'd0, m_tvalid, m_tlast}, 32'd3);
    b1 = m_tdata;
    if (!s_tready) lows++;
    for (int i = 0; i < st1; i++) begin
      @(posedge clk); #1;
      check_eq("b1_hold", m_tdata, b1);
      check_eq("b1_hold_vl", {30'd0, m_tvalid, m_tlast}, 32'd3);
      if (!s_tready) lows++;
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
    check_eq("done_valid", 32'(m_tvalid), 32'd0);
    check_eq("done_rdy", 32'(s_tready), 32'd1);
  endtask

  initial begin
    logic [31:0] b0, b1;
    int lows, beat, sums, overlap, n;
    logic rdy;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(m_tvalid), 32'd0);
    check_eq("rst_data", m_tdata, 32'd0);
    check_eq("rst_last", 32'(m_tlast), 32'd0);
    check_eq("rst_strb", 32'(m_tstrb), 32'hF);
    check_eq("rst_rdy", 32'(s_tready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rdy_after_rst", 32'(s_tready), 32'd1);

    // four-beat frame with a tie at the peak
    send_beat(16'd5, 16'h0010, 1'b0);
    send_beat(16'd9, 16'h0020, 1'b0);
    send_beat(16'd9, 16'h0030, 1'b0);
    send_beat(16'd3, 16'h0040, 1'b1);
    get_summary(b0, b1, 0, 0, lows);
    check_eq("f1_b0", b0, 32'h0009_0020);
    check_eq("f1_b1", b1, 32'h0004_0001);
    check_eq("f1_lows", 32'(lows), 32'd2);

    // single-beat frame
    send_beat(16'hFFFF, 16'h8000, 1'b1);
    get_summary(b0, b1, 0, 0, lows);
    check_eq("f2_b0", b0, 32'hFFFF_8000);
    check_eq("f2_b1", b1, 32'h0001_0000);

    // backpressure on both summary beats
    send_beat(16'd5, 16'h0010, 1'b0);
    send_beat(16'd9, 16'h0020, 1'b0);
    send_beat(16'd9, 16'h0030, 1'b0);
    send_beat(16'd3, 16'h0040, 1'b1);
    get_summary(b0, b1, 5, 3, lows);
    check_eq("f3_b0", b0, 32'h0009_0020);
    check_eq("f3_b1", b1, 32'h0004_0001);
    check_eq("f3_lows", 32'(lows), 32'd10);

    // reset in the middle of a frame
    send_beat(16'd7, 16'h0070, 1'b0);
    send_beat(16'd8, 16'h0080, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rdy", 32'(s_tready), 32'd0);
    check_eq("mid_rst_valid", 32'(m_tvalid), 32'd0);
    #10;
    rst_n = 1'b1;
    send_beat(16'd1, 16'h0100, 1'b0);
    send_beat(16'd2, 16'h0200, 1'b1);
    get_summary(b0, b1, 0, 0, lows);
    check_eq("f4_b0", b0, 32'h0002_0200);
    check_eq("f4_b1", b1, 32'h0002_0001);

    // long ramp frame saturates the counter
    for (int i = 0; i < 70000; i++)
      send_beat(16'(i), 16'(i) ^ 16'h5A5A, i == 69999);
    get_summary(b0, b1, 0, 0, lows);
    check_eq("f5_b0", b0, 32'hFFFF_A5A5);
    check_eq("f5_b1", b1, 32'hFFFF_FFFF);

    // back-to-back 3-beat frames with tvalid held high
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    beat = 0; sums = 0; overlap = 0; n = 0;
    while (beat < 30 && n < 200) begin
      s_tdata = {16'(beat % 3 + 1), 16'(beat)};
      s_tlast = (beat % 3 == 2);
      rdy = s_tready;
      @(posedge clk); #1;
      n++;
      if (rdy) beat++;
      if (m_tvalid && s_tready) overlap++;
      if (m_tvalid && m_tlast) begin
        sums++;
        check_eq("b2b_b1", m_tdata, 32'h0003_0002);
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (m_tvalid && m_tlast) begin
        sums++;
        check_eq("b2b_b1", m_tdata, 32'h0003_0002);
      end
    end
    m_tready = 1'b0;
    check_eq("b2b_beats", 32'(beat), 32'd30);
    check_eq("b2b_frames", 32'(sums), 32'd10);
    check_eq("b2b_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
